// File: rtl/vga_pkg.sv
// Shared VGA timing package: 640x480@60 geometry, counter widths, RGB332
// field masks and the sync/blank bundle carried through the delay pipe.
package vga_pkg;

  // 640x480@60 timing (pixels / lines)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Raster counter widths shared with the sprite drawers
  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  // RGB332 pixel fields: RRRGGGBB
  localparam logic [7:0] RGB_R_MASK = 8'hE0;
  localparam logic [7:0] RGB_G_MASK = 8'h1C;
  localparam logic [7:0] RGB_B_MASK = 8'h03;
  localparam logic [7:0] RGB_BLACK  = 8'h00;

  // Un-polarised sync/blank bundle; idle = no sync pulse, blanked
  typedef struct packed {
    logic hs;
    logic vs;
    logic bl;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b0, vs: 1'b0, bl: 1'b1};

  // Half-open window test lo <= val < hi, all unsigned at counter width
  function automatic logic in_span(input logic [HCNT_W-1:0] val,
                                   input logic [HCNT_W-1:0] lo,
                                   input logic [HCNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_delay_pipe.sv
// N-stage, W-bit shift register with an asynchronous reset value.
// Exposes a mid-pipe tap (stage TAP, 1-based) and the final stage.
module vga_delay_pipe #(
  parameter int            N       = 2,
  parameter int            W       = 3,
  parameter int            TAP     = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  tap,
  output logic [W-1:0]  dout
);

  logic [W-1:0] stage_reg [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        // First stage samples the input every clk
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg[gi] <= RST_VAL;
          else        stage_reg[gi] <= din;
        end
      end else begin : g_body
        // Later stages shift the previous stage every clk
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) stage_reg[gi] <= RST_VAL;
          else        stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tap  = stage_reg[TAP-1];
  assign dout = stage_reg[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: hcount/vcount for the sprite drawers, line/frame pulses,
// and the final sync/blank/rgb outputs aligned to the drawers' pixel latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIX_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [HCNT_W-1:0] hcount,
  output logic [VCNT_W-1:0] vcount,
  input  logic [7:0]        pixel_in,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic [7:0]        rgb,
  output logic              line_start,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
  localparam logic [HCNT_W-1:0] H_ACT    = HCNT_W'(H_ACTIVE);
  localparam logic [HCNT_W-1:0] HS_START = HCNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
  localparam logic [HCNT_W-1:0] V_ACT    = HCNT_W'(V_ACTIVE);
  localparam logic [HCNT_W-1:0] VS_START = HCNT_W'(V_ACTIVE + V_FP);
  localparam logic [HCNT_W-1:0] VS_END   = HCNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HCNT_W-1:0] hcount_reg, hcount_next;
  logic [VCNT_W-1:0] vcount_reg, vcount_next;
  logic              h_wrap, v_wrap;
  logic              line_start_reg, frame_start_reg;
  logic [7:0]        rgb_reg;
  logic [HCNT_W-1:0] vcount_ext;
  sync_t             raw_sync, tap_sync, out_sync;

  assign h_wrap     = (hcount_reg == H_LAST);
  assign v_wrap     = (vcount_reg == V_LAST);
  assign vcount_ext = {{(HCNT_W-VCNT_W){1'b0}}, vcount_reg};

  // Next raster position: h wraps at end of line, v steps only on h wrap
  always_comb begin
    hcount_next = h_wrap ? '0 : hcount_reg + 1'b1;
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = v_wrap ? '0 : vcount_reg + 1'b1;
    end
  end

  // Raster counters and line/frame pulses advance only on pixel-enable clks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (pix_en) begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      line_start_reg  <= h_wrap;
      frame_start_reg <= h_wrap && v_wrap;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  // Raw sync/blank decode from the registered counters
  always_comb begin
    raw_sync.hs = in_span(hcount_reg, HS_START, HS_END);
    raw_sync.vs = in_span(vcount_ext, VS_START, VS_END);
    raw_sync.bl = (hcount_reg >= H_ACT) || (vcount_ext >= V_ACT);
  end

  // Sync/blank delay line: stage PIX_LAT gates the pixel register, the last
  // stage drives the pins so they line up with rgb
  vga_delay_pipe #(
    .N       (PIX_LAT + 1),
    .W       ($bits(sync_t)),
    .TAP     (PIX_LAT),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (raw_sync),
    .tap   (tap_sync),
    .dout  (out_sync)
  );

  // Output pixel register: drawer pixel, forced black while blanked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           rgb_reg <= RGB_BLACK;
    else if (tap_sync.bl) rgb_reg <= RGB_BLACK;
    else                  rgb_reg <= pixel_in;
  end

  assign hcount      = hcount_reg;
  assign vcount      = vcount_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign rgb         = rgb_reg;
  assign blank       = out_sync.bl;
  assign hsync       = out_sync.hs ^ ~SYNC_POL;
  assign vsync       = out_sync.vs ^ ~SYNC_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a tiny-raster
// instance (active-high sync, 2-clk drawer latency) share clk/rst_n/pix_en.
// The reference model tracks a linear raster position per instance and a
// per-edge history, from which every output is derived arithmetically.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_en = 1'b0;
  logic [7:0]  pixel_in0 = 8'h00, pixel_in1 = 8'h00;
  logic [10:0] hcount0, hcount1;
  logic [9:0]  vcount0, vcount1;
  logic        hsync0, vsync0, blank0, line_start0, frame_start0;
  logic        hsync1, vsync1, blank1, line_start1, frame_start1;
  logic [7:0]  rgb0, rgb1;

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hcount0), .vcount(vcount0), .pixel_in(pixel_in0),
    .hsync(hsync0), .vsync(vsync0), .blank(blank0), .rgb(rgb0),
    .line_start(line_start0), .frame_start(frame_start0)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .PIX_LAT(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hcount1), .vcount(vcount1), .pixel_in(pixel_in1),
    .hsync(hsync1), .vsync(vsync1), .blank(blank1), .rgb(rgb1),
    .line_start(line_start1), .frame_start(frame_start1)
  );

  // Per-instance geometry, latency, polarity and ball sprite
  int ha[2] = '{640, 16};
  int hf[2] = '{16, 2};
  int hs[2] = '{96, 3};
  int hb[2] = '{48, 2};
  int va[2] = '{480, 8};
  int vf[2] = '{10, 1};
  int vs[2] = '{2, 2};
  int vb[2] = '{33, 1};
  int lat[2] = '{1, 2};
  int pol[2] = '{0, 1};
  int bx[2] = '{100, 3};
  int by[2] = '{50, 2};
  int bw[2] = '{32, 4};
  int ht[2], vt[2];

  // Model state
  int  pos[2];
  bit  ls_e[2], fs_e[2];
  int  hpos[2][8];
  bit  hidle[2][8];
  bit  hadv[2][8];
  int  pix_edge[2];
  int  ball_cnt[2], pe_cnt[2];
  bit  frame_clean[2];
  int  cyc = 0;
  int  cur_inst = 0;
  int  pe_mode = 0;     // 0 hold low, 1 always, 2 random ~90%, 3 every 2nd clk
  bit  noise = 1'b1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s inst%0d cyc%0d: got %0d, expected %0d",
                  tag, cur_inst, cyc, obs, exp);
  endtask

  function automatic bit f_hs(int i, int p);
    int h = p % ht[i];
    return (h >= ha[i] + hf[i]) && (h < ha[i] + hf[i] + hs[i]);
  endfunction

  function automatic bit f_vs(int i, int p);
    int v = p / ht[i];
    return (v >= va[i] + vf[i]) && (v < va[i] + vf[i] + vs[i]);
  endfunction

  function automatic bit f_bl(int i, int p);
    return ((p % ht[i]) >= ha[i]) || ((p / ht[i]) >= va[i]);
  endfunction

  function automatic bit f_ball(int i, int p);
    int h = p % ht[i];
    int v = p / ht[i];
    return (h >= bx[i]) && (h < bx[i] + bw[i]) && (v >= by[i]) && (v < by[i] + bw[i]);
  endfunction

  // Advance the model at a clock edge using the inputs present at that edge
  task automatic edge_update();
    int slot;
    cyc++;
    slot = cyc % 8;
    for (int i = 0; i < 2; i++) begin
      hidle[i][slot] = !rst_n;
      hpos[i][slot]  = pos[i];
      pix_edge[i]    = (i == 0) ? int'(pixel_in0) : int'(pixel_in1);
      if (!rst_n) begin
        pos[i] = 0; ls_e[i] = 0; fs_e[i] = 0; hadv[i][slot] = 0;
        frame_clean[i] = 0; pe_cnt[i] = 0; ball_cnt[i] = 0;
      end else if (pix_en) begin
        pos[i] = (pos[i] + 1) % (ht[i] * vt[i]);
        ls_e[i] = (pos[i] % ht[i]) == 0;
        fs_e[i] = (pos[i] == 0);
        hadv[i][slot] = 1;
        pe_cnt[i]++;
      end else begin
        ls_e[i] = 0; fs_e[i] = 0; hadv[i][slot] = 0;
      end
    end
  endtask

  task automatic check_inst(input int i, input int hc, input int vc, input bit hsy,
                            input bit vsy, input bit bl, input int rgbv,
                            input bit ls, input bit fs);
    int  t = cyc;
    int  L = lat[i];
    bit  idle = 0;
    int  p;
    bit  bl_e, hs_r, vs_r;
    int  rgb_e;
    cur_inst = i;
    for (int k = 0; k <= L; k++)
      if (t - k < 1 || hidle[i][(t - k) % 8]) idle = 1;
    p    = (t - L >= 1) ? hpos[i][(t - L) % 8] : 0;
    bl_e = idle ? 1'b1 : f_bl(i, p);
    hs_r = idle ? 1'b0 : f_hs(i, p);
    vs_r = idle ? 1'b0 : f_vs(i, p);
    rgb_e = bl_e ? 0 : pix_edge[i];
    check_eq("hcount", hc, pos[i] % ht[i]);
    check_eq("vcount", vc, pos[i] / ht[i]);
    check_eq("line_start", int'(ls), int'(ls_e[i]));
    check_eq("frame_start", int'(fs), int'(fs_e[i]));
    check_eq("hsync", int'(hsy), pol[i] ? int'(hs_r) : int'(!hs_r));
    check_eq("vsync", int'(vsy), pol[i] ? int'(vs_r) : int'(!vs_r));
    check_eq("blank", int'(bl), int'(bl_e));
    check_eq("rgb", rgbv, rgb_e);
    // Ball pixels shown per frame: count each newly displayed raster position once
    if (!noise && !idle && t - L - 1 >= 1 && hadv[i][(t - L - 1) % 8] &&
        rgbv == 8'hFF && !bl)
      ball_cnt[i]++;
    if (fs) begin
      if (frame_clean[i]) begin
        check_eq("ball_pixels", ball_cnt[i], bw[i] * bw[i]);
        check_eq("frame_len", pe_cnt[i], ht[i] * vt[i]);
      end
      ball_cnt[i] = 0;
      pe_cnt[i] = 0;
      frame_clean[i] = !noise;
    end
  endtask

  task automatic drive_next();
    logic [31:0] r;
    int pv[2];
    case (pe_mode)
      0: pix_en = 1'b0;
      1: pix_en = 1'b1;
      2: pix_en = ($urandom_range(0, 9) != 0);
      default: pix_en = (cyc % 2 == 0);
    endcase
    for (int i = 0; i < 2; i++) begin
      int idx = cyc + 1 - lat[i];
      r = $urandom;
      if (noise) pv[i] = (r[9:8] == 2'b00) ? 8'hFF : int'(r[7:0]);
      else if (idx < 1 || hidle[i][idx % 8]) pv[i] = 0;
      else pv[i] = f_ball(i, hpos[i][idx % 8]) ? 8'hFF : 0;
    end
    pixel_in0 = 8'(pv[0]);
    pixel_in1 = 8'(pv[1]);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    edge_update();
    @(negedge clk);
    check_inst(0, int'(hcount0), int'(vcount0), hsync0, vsync0, blank0, int'(rgb0),
               line_start0, frame_start0);
    check_inst(1, int'(hcount1), int'(vcount1), hsync1, vsync1, blank1, int'(rgb1),
               line_start1, frame_start1);
    drive_next();
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic check_async_reset();
    #1;
    cur_inst = 0;
    check_eq("rst_hcount", int'(hcount0), 0);
    check_eq("rst_vcount", int'(vcount0), 0);
    check_eq("rst_rgb", int'(rgb0), 0);
    check_eq("rst_blank", int'(blank0), 1);
    check_eq("rst_hsync", int'(hsync0), 1);
    check_eq("rst_vsync", int'(vsync0), 1);
    check_eq("rst_line_start", int'(line_start0), 0);
    cur_inst = 1;
    check_eq("rst_hcount", int'(hcount1), 0);
    check_eq("rst_hsync", int'(hsync1), 0);
    check_eq("rst_frame_start", int'(frame_start1), 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ht[i] = ha[i] + hf[i] + hs[i] + hb[i];
      vt[i] = va[i] + vf[i] + vs[i] + vb[i];
      pos[i] = 0; ls_e[i] = 0; fs_e[i] = 0;
      ball_cnt[i] = 0; pe_cnt[i] = 0; frame_clean[i] = 0; pix_edge[i] = 0;
      for (int k = 0; k < 8; k++) begin
        hidle[i][k] = 1; hpos[i][k] = 0; hadv[i][k] = 0;
      end
    end

    // Power-on reset, then free-run to hcount=300 and reset mid-line
    run_n(3);
    rst_n = 1'b1;
    pe_mode = 1;
    pix_en = 1'b1;
    for (int k = 0; k < 1000 && pos[0] != 300; k++) run_cycle();
    cur_inst = 0;
    check_eq("pre_rst_hcount", int'(hcount0), 300);
    rst_n = 1'b0;
    check_async_reset();
    run_n(4);
    rst_n = 1'b1;

    // Random enables with random/forced-FF pixels (blanking coverage)
    pe_mode = 2;
    run_n(3000);

    // Ball drawer driving pixel_in, random enables
    noise = 1'b0;
    run_n(45000);

    // Enable every 2nd clk, then hold low so the pipe drains
    pe_mode = 3;
    run_n(6000);
    pe_mode = 0;
    run_n(10);

    // Reset mid-frame, then resume
    rst_n = 1'b0;
    check_async_reset();
    run_n(2);
    rst_n = 1'b1;
    pe_mode = 2;
    run_n(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
